// File: rtl/snn_delay_layer.sv
// Single leaky integrate-and-fire layer with per-synapse axonal delays and ternary weights.
// One timestep is accepted on a valid/ready handshake, synapses are accumulated serially
// (one input line per cycle, all neurons in parallel), then membranes are updated and the
// step result is held on a valid/ready output until taken.
module snn_delay_layer #(
    parameter int unsigned M     = 8,
    parameter int unsigned N     = 8,
    parameter int unsigned MP_W  = 6,
    parameter int unsigned DLY_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [M-1:0]         in_spikes,
    input  logic [N*M*2-1:0]     weights,
    input  logic [N*M*DLY_W-1:0] delays,
    input  logic [MP_W-2:0]      threshold,
    input  logic [MP_W-2:0]      decay,
    input  logic [3:0]           refractory_period,
    input  logic                 reset_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_spikes,
    output logic [N*MP_W-1:0]    membrane_potential_out,
    output logic                 busy
);

    localparam int unsigned D  = 1 << DLY_W;
    localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;

    localparam logic signed [MP_W-1:0] MP_MAX = {1'b0, {(MP_W-1){1'b1}}};
    localparam logic signed [MP_W-1:0] MP_MIN = {1'b1, {(MP_W-1){1'b0}}};
    localparam logic signed [MP_W-1:0] MP_ONE = {{(MP_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;
    localparam logic [1:0] ST_OUT    = 2'd3;

    logic [1:0]              state_q;
    logic [IW-1:0]           m_idx_q;
    // hist_q[m][k] is the spike seen on line m k steps ago (k = 0 is the current step)
    logic [M-1:0][D-1:0]     hist_q;
    logic signed [MP_W-1:0]  v_q   [N];
    logic signed [MP_W-1:0]  acc_q [N];
    logic [3:0]              refr_q [N];
    logic [N-1:0]            out_spikes_q;
    logic [N*MP_W-1:0]       mp_out_q;

    logic [1:0]              w_cur    [N];
    logic [DLY_W-1:0]        d_cur    [N];
    logic signed [MP_W-1:0]  acc_step [N];
    logic signed [MP_W-1:0]  v_upd    [N];
    logic [3:0]              refr_upd [N];
    logic [N-1:0]            spk_upd;

    logic signed [MP_W-1:0]  thr_s;
    logic signed [MP_W:0]    dec_s;

    assign thr_s = $signed({1'b0, threshold});
    assign dec_s = $signed({2'b00, decay});

    assign in_ready               = (state_q == ST_IDLE);
    assign out_valid              = (state_q == ST_OUT);
    assign busy                   = (state_q != ST_IDLE);
    assign out_spikes             = out_spikes_q;
    assign membrane_potential_out = mp_out_q;

    // Select the weight and delay of synapse (n, m_idx) for every neuron
    always_comb begin
        for (int n = 0; n < N; n++) begin
            w_cur[n] = weights[(n * M + int'(m_idx_q)) * 2 +: 2];
            d_cur[n] = delays[(n * M + int'(m_idx_q)) * DLY_W +: DLY_W];
        end
    end

    // Saturating +/-1 accumulation of the current input line into every neuron
    always_comb begin
        for (int n = 0; n < N; n++) begin
            acc_step[n] = acc_q[n];
            if (hist_q[m_idx_q][d_cur[n]] && !w_cur[n][1]) begin
                if (w_cur[n][0]) begin
                    if (acc_q[n] != MP_MIN) begin
                        acc_step[n] = acc_q[n] - MP_ONE;
                    end
                end else begin
                    if (acc_q[n] != MP_MAX) begin
                        acc_step[n] = acc_q[n] + MP_ONE;
                    end
                end
            end
        end
    end

    // Membrane update: refractory hold, fire-and-reset, or leak toward zero
    always_comb begin
        logic signed [MP_W:0] acc_ext;
        logic signed [MP_W:0] leak_tmp;
        for (int n = 0; n < N; n++) begin
            v_upd[n]    = '0;
            refr_upd[n] = '0;
            spk_upd[n]  = 1'b0;
            acc_ext     = {acc_q[n][MP_W-1], acc_q[n]};
            leak_tmp    = '0;
            if (refr_q[n] != 4'd0) begin
                refr_upd[n] = refr_q[n] - 4'd1;
            end else if (acc_q[n] >= thr_s) begin
                spk_upd[n]  = 1'b1;
                refr_upd[n] = refractory_period;
                // acc >= threshold >= 0, so the difference cannot leave the range
                if (reset_mode) begin
                    v_upd[n] = acc_q[n] - thr_s;
                end
            end else if (acc_q[n] > 0) begin
                leak_tmp = acc_ext - dec_s;
                v_upd[n] = leak_tmp[MP_W] ? '0 : leak_tmp[MP_W-1:0];
            end else if (acc_q[n] < 0) begin
                leak_tmp = acc_ext + dec_s;
                v_upd[n] = (leak_tmp > 0) ? '0 : leak_tmp[MP_W-1:0];
            end
        end
    end

    // Step sequencer and all layer state; clear behaves like a synchronous copy of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            m_idx_q      <= '0;
            hist_q       <= '0;
            out_spikes_q <= '0;
            mp_out_q     <= '0;
            for (int n = 0; n < N; n++) begin
                v_q[n]    <= '0;
                acc_q[n]  <= '0;
                refr_q[n] <= '0;
            end
        end else if (clear) begin
            state_q      <= ST_IDLE;
            m_idx_q      <= '0;
            hist_q       <= '0;
            out_spikes_q <= '0;
            mp_out_q     <= '0;
            for (int n = 0; n < N; n++) begin
                v_q[n]    <= '0;
                acc_q[n]  <= '0;
                refr_q[n] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int m = 0; m < M; m++) begin
                            hist_q[m] <= {hist_q[m][D-2:0], in_spikes[m]};
                        end
                        for (int n = 0; n < N; n++) begin
                            acc_q[n] <= v_q[n];
                        end
                        m_idx_q <= '0;
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    for (int n = 0; n < N; n++) begin
                        acc_q[n] <= acc_step[n];
                    end
                    m_idx_q <= m_idx_q + IW'(1);
                    if (m_idx_q == IW'(M - 1)) begin
                        state_q <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    for (int n = 0; n < N; n++) begin
                        v_q[n]                      <= v_upd[n];
                        refr_q[n]                   <= refr_upd[n];
                        mp_out_q[n*MP_W +: MP_W]    <= v_upd[n];
                    end
                    out_spikes_q <= spk_upd;
                    state_q      <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_delay_layer.sv
// Directed bench for snn_delay_layer: a behavioural LIF model pushes expected step results
// to a scoreboard queue when a step is driven; they are popped when out_valid appears.
module tb_snn_delay_layer;

    localparam int unsigned M     = 8;
    localparam int unsigned N     = 8;
    localparam int unsigned MP_W  = 6;
    localparam int unsigned DLY_W = 3;
    localparam int unsigned D     = 1 << DLY_W;
    localparam int          VMAX  = (1 << (MP_W - 1)) - 1;
    localparam int          VMIN  = -(1 << (MP_W - 1));

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 clear = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [M-1:0]         in_spikes = '0;
    logic [N*M*2-1:0]     weights = '1;
    logic [N*M*DLY_W-1:0] delays = '0;
    logic [MP_W-2:0]      threshold = '0;
    logic [MP_W-2:0]      decay = '0;
    logic [3:0]           refractory_period = '0;
    logic                 reset_mode = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [N-1:0]         out_spikes;
    logic [N*MP_W-1:0]    membrane_potential_out;
    logic                 busy;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [N-1:0]      spk;
        logic [N*MP_W-1:0] mp;
    } exp_t;
    exp_t sb[$];

    int           mv[N];
    int           mrefr[N];
    logic [D-1:0] mhist[M];

    snn_delay_layer #(.M(M), .N(N), .MP_W(MP_W), .DLY_W(DLY_W)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .clear                  (clear),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_spikes              (in_spikes),
        .weights                (weights),
        .delays                 (delays),
        .threshold              (threshold),
        .decay                  (decay),
        .refractory_period      (refractory_period),
        .reset_mode             (reset_mode),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_spikes             (out_spikes),
        .membrane_potential_out (membrane_potential_out),
        .busy                   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int sat(input int x);
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return x;
    endfunction

    function automatic logic [MP_W-1:0] mpv(input int x);
        return x[MP_W-1:0];
    endfunction

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            mv[n]    = 0;
            mrefr[n] = 0;
        end
        for (int m = 0; m < M; m++) mhist[m] = '0;
        sb.delete();
    endtask

    // Reference LIF step for all neurons; pushes the expected result
    task automatic model_step(input logic [M-1:0] spk);
        exp_t             e;
        int               acc;
        int               thr;
        int               dec;
        logic [1:0]       w;
        logic [DLY_W-1:0] d;
        thr = int'(threshold);
        dec = int'(decay);
        for (int m = 0; m < M; m++) mhist[m] = {mhist[m][D-2:0], spk[m]};
        for (int n = 0; n < N; n++) begin
            acc = mv[n];
            for (int m = 0; m < M; m++) begin
                w = weights[(n*M+m)*2 +: 2];
                d = delays[(n*M+m)*DLY_W +: DLY_W];
                if (mhist[m][d] && w == 2'b00) acc = sat(acc + 1);
                if (mhist[m][d] && w == 2'b01) acc = sat(acc - 1);
            end
            e.spk[n] = 1'b0;
            if (mrefr[n] > 0) begin
                mv[n] = 0;
                mrefr[n]--;
            end else if (acc >= thr) begin
                e.spk[n] = 1'b1;
                mv[n]    = reset_mode ? acc - thr : 0;
                mrefr[n] = int'(refractory_period);
            end else if (acc > 0) begin
                mv[n] = (acc - dec > 0) ? acc - dec : 0;
            end else begin
                mv[n] = (acc + dec < 0) ? acc + dec : 0;
            end
            e.mp[n*MP_W +: MP_W] = mpv(mv[n]);
        end
        sb.push_back(e);
    endtask

    // One full timestep: handshake in, wait for result, compare against scoreboard, take it
    task automatic do_step(input logic [M-1:0] spk, output logic [N-1:0] o_spk,
                           output logic [N*MP_W-1:0] o_mp);
        int   edges;
        exp_t e;
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_spikes = spk;
        model_step(spk);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_spikes = '0;
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        chk("latency", 64'(edges + 1), 64'(M + 2));
        o_spk = out_spikes;
        o_mp  = membrane_potential_out;
        e = sb.pop_front();
        chk("sb_spikes", 64'(o_spk), 64'(e.spk));
        chk("sb_mp", 64'(o_mp), 64'(e.mp));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_spikes"}, 64'(out_spikes), 64'd0);
        chk({tag, "_mp"}, 64'(membrane_potential_out), 64'd0);
    endtask

    initial begin
        logic [N-1:0]      o_spk;
        logic [N*MP_W-1:0] o_mp;
        logic [N-1:0]      hold_spk;
        logic [N*MP_W-1:0] hold_mp;
        int                edges;
        int                seen;

        model_reset();
        #1;
        chk_idle_zero("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Leak config, a few steps to get nonzero state, then reset mid-ACCUM
        weights = '1;
        weights[5:0] = 6'b000000;
        threshold = 5'd10;
        decay = 5'd1;
        reset_mode = 1'b0;
        refractory_period = 4'd0;
        for (int s = 0; s < 2; s++) do_step(8'h07, o_spk, o_mp);
        chk("pre_reset_v0", 64'(o_mp[MP_W-1:0]), 64'(mpv(4)));
        @(negedge clk);
        in_valid = 1'b1;
        in_spikes = 8'h07;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_idle_zero("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Delay: line 0 delayed by 3 into neuron 0
        weights = '1;
        weights[1:0] = 2'b00;
        delays = '0;
        delays[DLY_W-1:0] = 3'd3;
        threshold = 5'd1;
        decay = 5'd0;
        refractory_period = 4'd0;
        for (int s = 0; s < 6; s++) begin
            do_step((s == 0) ? 8'h01 : 8'h00, o_spk, o_mp);
            chk($sformatf("delay_spk_s%0d", s), 64'(o_spk[0]), 64'(s == 3));
        end

        // Leak: v0 = 2,4,6,8 then spike at step 5
        pulse_clear();
        weights = '1;
        weights[5:0] = 6'b000000;
        delays = '0;
        threshold = 5'd10;
        decay = 5'd1;
        reset_mode = 1'b0;
        for (int s = 1; s <= 5; s++) begin
            do_step(8'h07, o_spk, o_mp);
            chk($sformatf("leak_v0_s%0d", s), 64'(o_mp[MP_W-1:0]),
                64'(mpv((s < 5) ? 2 * s : 0)));
            chk($sformatf("leak_spk_s%0d", s), 64'(o_spk[0]), 64'(s == 5));
        end

        // Subtract-threshold reset: spike every step, v0 = 3,6,9,12
        pulse_clear();
        weights = '1;
        weights[15:0] = '0;
        threshold = 5'd5;
        decay = 5'd0;
        reset_mode = 1'b1;
        refractory_period = 4'd0;
        for (int s = 1; s <= 4; s++) begin
            do_step(8'hFF, o_spk, o_mp);
            chk($sformatf("rm1_v0_s%0d", s), 64'(o_mp[MP_W-1:0]), 64'(mpv(3 * s)));
            chk($sformatf("rm1_spk_s%0d", s), 64'(o_spk[0]), 64'd1);
        end

        // Zero reset with refractory 2: spikes at steps 1 and 4 only
        pulse_clear();
        reset_mode = 1'b0;
        refractory_period = 4'd2;
        for (int s = 1; s <= 5; s++) begin
            do_step(8'hFF, o_spk, o_mp);
            chk($sformatf("refr_spk_s%0d", s), 64'(o_spk[0]), 64'(s == 1 || s == 4));
        end

        // Saturation: all weights -1, potentials clamp at the negative limit
        pulse_clear();
        weights = {(N*M){2'b01}};
        threshold = 5'd31;
        decay = 5'd0;
        refractory_period = 4'd0;
        for (int s = 1; s <= 8; s++) begin
            do_step(8'hFF, o_spk, o_mp);
            chk($sformatf("sat_v0_s%0d", s), 64'(o_mp[MP_W-1:0]),
                64'(mpv((-8 * s < VMIN) ? VMIN : -8 * s)));
            chk($sformatf("sat_v7_s%0d", s), 64'(o_mp[7*MP_W +: MP_W]),
                64'(mpv((-8 * s < VMIN) ? VMIN : -8 * s)));
            chk($sformatf("sat_spk_s%0d", s), 64'(o_spk), 64'd0);
        end

        // Backpressure: outputs held while out_ready is low, new input ignored
        pulse_clear();
        weights = '1;
        weights[15:0] = '0;
        threshold = 5'd5;
        reset_mode = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_spikes = 8'hFF;
        model_step(8'hFF);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        chk("bp_latency", 64'(edges + 1), 64'(M + 2));
        hold_spk = out_spikes;
        hold_mp = membrane_potential_out;
        begin
            exp_t e;
            e = sb.pop_front();
            chk("bp_spikes", 64'(hold_spk), 64'(e.spk));
            chk("bp_mp", 64'(hold_mp), 64'(e.mp));
        end
        in_valid = 1'b1;
        in_spikes = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp_hold_spk_c%0d", c), 64'(out_spikes), 64'(hold_spk));
            chk($sformatf("bp_hold_mp_c%0d", c), 64'(membrane_potential_out), 64'(hold_mp));
            chk($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'd0);
            chk($sformatf("bp_valid_c%0d", c), 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        in_spikes = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        // The ignored input must not have been captured: next step follows the model
        do_step(8'hFF, o_spk, o_mp);

        // Clear during ACCUM cycle 3 discards the step and all state
        @(negedge clk);
        in_valid = 1'b1;
        in_spikes = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_spikes = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        chk_idle_zero("clr");
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("clr_no_valid", 64'(seen), 64'd0);
        // History must be empty: every delay tap of neuron 0 would otherwise see a spike
        for (int m = 0; m < M; m++) delays[m*DLY_W +: DLY_W] = DLY_W'(m);
        threshold = 5'd1;
        do_step(8'h00, o_spk, o_mp);
        chk("clr_hist_v0", 64'(o_mp[MP_W-1:0]), 64'd0);
        chk("clr_hist_spk", 64'(o_spk[0]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snn_delay_layer.md
# snn_delay_layer

Parametrised single-layer leaky integrate-and-fire layer with per-synapse programmable axonal delays and ternary weights. It runs in a single clock domain with a valid/ready timestep handshake in place of a separate delay clock. Synapses are accumulated serially, one input line per cycle. Layers chain output-to-input to build multi-layer SNNs.

## Interface
- M, 8, input spike lines (synapses per neuron)
- N, 8, neurons
- MP_W, 6, membrane potential width, two's complement
- DLY_W, 3, delay field width; delay range 0..2^DLY_W-1 timesteps
- clk  in  1  clock; one clock; reset is asynchronous and active-low
- reset  in  1  asynchronous reset, active-low (0 = reset)
- clear  in  1  synchronous soft clear
- in_valid  in  1  timestep input valid
- in_ready  out  1  block can accept a timestep
- in_spikes  in  M  input spikes for this timestep
- weights  in  N*M*2  weight of synapse (n,m) at bits [(n*M+m)*2 +: 2]: 2'b00=+1, 2'b01=-1, 2'b1x=0
- delays  in  N*M*DLY_W  delay of synapse (n,m) at [(n*M+m)*DLY_W +: DLY_W]
- threshold  in  MP_W-1  firing threshold, unsigned
- decay  in  MP_W-1  leak per timestep, unsigned
- refractory_period  in  4  timesteps of refractoriness after a spike
- reset_mode  in  1  0 = reset to zero on spike, 1 = subtract threshold
- out_valid  out  1  step result valid
- out_ready  in  1  downstream accepts result
- out_spikes  out  N  spikes for the completed step
- membrane_potential_out  out  N*MP_W  potentials after the step; neuron n at [n*MP_W +: MP_W]
- busy  out  1  high when not IDLE

## Operation
- FSM states: IDLE -> ACCUM -> UPDATE -> OUT -> IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, the history is updated: per line m, hist[m] <= {hist[m][D-2:0], in_spikes[m]} with D=2^DLY_W, so hist[m][k] is the spike k steps ago. acc[n] <= v[n] for all n. m_idx <= 0. Go to ACCUM.
- ACCUM: lasts M cycles, m_idx = 0..M-1. For every neuron n in parallel: if hist[m][delays(n,m)]=1 and the weight is nonzero, acc[n] <= sat(acc[n] ± 1). After m_idx=M-1, go to UPDATE.
- UPDATE, per neuron:
  - If refr[n]>0: v <= 0, refr <= refr-1, no spike.
  - Else if acc >= threshold (compared as signed against zero-extended threshold): spike. v <= 0 (reset_mode=0) or acc-threshold (reset_mode=1). refr <= refractory_period.
  - Else leak toward zero: v>0 gives max(v-decay,0); v<0 gives min(v+decay,0).
  - Register out_spikes and potentials, then go to OUT.
- OUT: out_valid=1. Outputs are held stable until out_ready. On the handshake, go to IDLE.
- Saturation: all sums clamp to [-2^(MP_W-1), 2^(MP_W-1)-1] and never wrap.
- threshold=0: every non-refractory neuron with acc>=0 fires.
- delay=0 uses the current step's spike. delay=D-1 uses the oldest retained spike.
- weights, delays and the parameter inputs must be stable from acceptance until out_valid. They are sampled combinationally in ACCUM and UPDATE.
- clear is honoured in any state and takes priority over the handshake. Next cycle: IDLE; v, refr, hist, acc, out_spikes, membrane_potential_out all zero; out_valid=0. An in-flight step is discarded.
- reset asserted: the same state as clear, applied asynchronously. Takes effect mid-step.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_spikes=0, membrane_potential_out=0.
- Input handshake at edge E0. ACCUM covers cycles E0+1..E0+M. UPDATE at E0+M+1. out_valid is high from E0+M+2; latency is M+2 cycles (10 for M=8).
- in_ready is low from E0+1 until the cycle after the output handshake. Maximum throughput is one step per M+3 cycles.
- in_valid while in_ready=0 is ignored; in_spikes are not captured.

## Test plan
- Reset: hold reset=0 mid-ACCUM → next sample shows all outputs 0 and in_ready=1. After release, the first step behaves as from power-up.
- Delay:
  - Setup: w(0,0)=+1, d(0,0)=3, all other weights 0. threshold=1, decay=0, refractory_period=0.
  - Stimulus: in_spikes=8'h01 at step 0, then zeros.
  - Required: out_spikes[0]=1 only at step 3, and each out_valid arrives 10 cycles after acceptance.
- Leak:
  - Setup: w(0,0..2)=+1, threshold=10, decay=1, reset_mode=0.
  - Stimulus: in_spikes=8'h07 on every step.
  - Required: v0 = 2,4,6,8, then a spike at step 5 with v0=0.
- Reset mode and refractory:
  - Setup: all eight weights of neuron 0 = +1, input 8'hFF every step, threshold=5.
  - With reset_mode=1, refractory_period=0: spikes every step, v0 = 3, 6, 9, ...
  - With reset_mode=0, refractory_period=2: spikes at steps 1 and 4, none at steps 2-3.
- Saturation: all weights -1, threshold=31, input 8'hFF for 8 steps → v = -8, -16, -24, -32, then held at -32. No wrap and no spikes.
- Backpressure/clear:
  - Hold out_ready=0 for 5 cycles in OUT → out_spikes and potentials stay stable, in_ready=0.
  - Pulse clear during ACCUM cycle 3 → IDLE next cycle, all potentials and history 0, and no out_valid for that step.
